// File: rtl/dot_product_stream_engine.sv
// Streaming signed dot-product engine: LANES-wide beats folded through MULTS
// multipliers, reduced in a registered adder tree and accumulated into ACC_W bits.
module dpse_lane_mul #(
  parameter int W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en_i,
  input  logic [W-1:0]          a_i,
  input  logic [W-1:0]          b_i,
  output logic signed [2*W-1:0] p_q
);
  always_ff @(posedge clk) begin
    if (reset)     p_q <= '0;
    else if (en_i) p_q <= $signed(a_i) * $signed(b_i);
  end
endmodule

module dot_product_stream_engine #(
  parameter int W     = 32,
  parameter int LANES = 8,
  parameter int MULTS = 4,
  parameter int ACC_W = 80
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic [15:0]          len_beats_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [W*LANES-1:0]   a_vec_i,
  input  logic [W*LANES-1:0]   b_vec_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [ACC_W-1:0]     result_o,
  output logic                 overflow_o,
  output logic                 busy_o
);
  localparam int F  = LANES / MULTS;
  localparam int FW = (F > 1) ? $clog2(F) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e                   state_q;
  logic [15:0]              beats_q;
  logic [W*LANES-1:0]       hold_a_q, hold_b_q;
  logic [FW-1:0]            fold_q;
  // [0] holding register full, [1] products valid, [2] tree sum valid
  logic [2:0]               vld_pipe_q;
  logic signed [2*W-1:0]    prod_q [MULTS];
  logic signed [ACC_W-1:0]  sum_d, sum_q, acc_q, acc_sum;
  logic                     ovf_q, ovf_step;
  logic [MULTS-1:0][W-1:0]  sl_a, sl_b;
  logic                     last_slice, issue, accept;

  assign last_slice = (fold_q == FW'(F - 1));
  assign issue      = vld_pipe_q[0];
  assign in_ready_o = (state_q == RUN) && (beats_q != 16'd0) && (!vld_pipe_q[0] || last_slice);
  assign accept     = in_valid_i && in_ready_o;

  always_comb begin
    sl_a = '0;
    sl_b = '0;
    for (int m = 0; m < MULTS; m++) begin
      int lane;
      lane = int'(fold_q) * MULTS + m;
      sl_a[m] = hold_a_q[(LANES-1-lane)*W +: W];
      sl_b[m] = hold_b_q[(LANES-1-lane)*W +: W];
    end
  end

  for (genvar m = 0; m < MULTS; m++) begin : g_mul
    dpse_lane_mul #(.W(W)) u_mul (
      .clk(clk), .reset(reset), .en_i(issue),
      .a_i(sl_a[m]), .b_i(sl_b[m]), .p_q(prod_q[m])
    );
  end

  always_comb begin
    sum_d = '0;
    for (int m = 0; m < MULTS; m++) sum_d = sum_d + ACC_W'(prod_q[m]);
  end

  // Signed overflow: same-sign operands producing a sum of the other sign.
  assign acc_sum  = acc_q + sum_q;
  assign ovf_step = (acc_q[ACC_W-1] == sum_q[ACC_W-1]) && (acc_sum[ACC_W-1] != acc_q[ACC_W-1]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      beats_q     <= '0;
      hold_a_q    <= '0;
      hold_b_q    <= '0;
      fold_q      <= '0;
      vld_pipe_q  <= '0;
      sum_q       <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      result_o    <= '0;
      overflow_o  <= 1'b0;
      out_valid_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      sum_q         <= sum_d;
      vld_pipe_q[1] <= vld_pipe_q[0];
      vld_pipe_q[2] <= vld_pipe_q[1];
      if (vld_pipe_q[2]) begin
        acc_q <= acc_sum;
        ovf_q <= ovf_q | ovf_step;
      end

      if (accept) begin
        hold_a_q      <= a_vec_i;
        hold_b_q      <= b_vec_i;
        vld_pipe_q[0] <= 1'b1;
        fold_q        <= '0;
        beats_q       <= beats_q - 16'd1;
      end else if (issue && last_slice) begin
        vld_pipe_q[0] <= 1'b0;
        fold_q        <= '0;
      end else if (issue) begin
        fold_q <= fold_q + 1'b1;
      end

      case (state_q)
        IDLE: if (start_i) begin
          acc_q      <= '0;
          ovf_q      <= 1'b0;
          result_o   <= '0;
          overflow_o <= 1'b0;
          busy_o     <= 1'b1;
          if (len_beats_i == 16'd0) begin
            out_valid_o <= 1'b1;
            state_q     <= DONE;
          end else begin
            beats_q <= len_beats_i;
            state_q <= RUN;
          end
        end
        RUN: if (accept && beats_q == 16'd1) state_q <= DRAIN;
        DRAIN: if (vld_pipe_q == 3'b000) begin
          result_o    <= acc_q;
          overflow_o  <= ovf_q;
          out_valid_o <= 1'b1;
          state_q     <= DONE;
        end
        DONE: if (out_ready_i) begin
          out_valid_o <= 1'b0;
          busy_o      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dot_product_stream_engine.sv
// Bench for dot_product_stream_engine: table-driven operations with a result
// scoreboard, plus stall, reset and narrow-accumulator overflow sequences.
module tb_dot_product_stream_engine;
  localparam int W = 32, L = 8, M = 4, A = 80;
  localparam int SW = 8, SL = 4, SM = 2, SA = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic           start, in_valid, in_ready, out_valid, out_ready, overflow, busy;
  logic [15:0]    len_beats;
  logic [W*L-1:0] a_vec, b_vec;
  logic [A-1:0]   result;

  logic            s_start, s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_overflow, s_busy;
  logic [15:0]     s_len;
  logic [SW*SL-1:0] s_a, s_b;
  logic [SA-1:0]   s_result;

  dot_product_stream_engine #(.W(W), .LANES(L), .MULTS(M), .ACC_W(A)) dut (
    .clk(clk), .reset(reset), .start_i(start), .len_beats_i(len_beats),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .a_vec_i(a_vec), .b_vec_i(b_vec),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .result_o(result),
    .overflow_o(overflow), .busy_o(busy)
  );

  dot_product_stream_engine #(.W(SW), .LANES(SL), .MULTS(SM), .ACC_W(SA)) dut_s (
    .clk(clk), .reset(reset), .start_i(s_start), .len_beats_i(s_len),
    .in_valid_i(s_in_valid), .in_ready_o(s_in_ready), .a_vec_i(s_a), .b_vec_i(s_b),
    .out_valid_o(s_out_valid), .out_ready_i(s_out_ready), .result_o(s_result),
    .overflow_o(s_overflow), .busy_o(s_busy)
  );

  typedef struct {
    int len; int a0; int as; int b0; int bs;
    logic signed [A-1:0] res; logic ovf; bit pchk;
  } vec_t;
  typedef struct { logic [A-1:0] res; logic ovf; } exp_t;

  vec_t tbl[7];
  exp_t sbq[$];
  int   n_chk = 0, n_pass = 0;

  task automatic chk(string name, logic [A-1:0] got, logic [A-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(vec_t e);
    for (int i = 0; i < L; i++) begin
      a_vec[(L-1-i)*W +: W] = W'(e.a0 + i * e.as);
      b_vec[(L-1-i)*W +: W] = W'(e.b0 + i * e.bs);
    end
  endtask

  // Issues start, streams the beats and waits for out_valid; checks latency.
  task automatic launch(vec_t e, string nm, bit push);
    int beats, g, pat, last;
    bit rdy;
    start = 1'b1; len_beats = 16'(e.len); in_valid = (e.len == 0);
    if (push) sbq.push_back('{res: e.res, ovf: e.ovf});
    tick();
    start = 1'b0;
    chk({nm, ".busy_rise"}, A'(busy), A'(1));
    if (e.len == 0) begin
      chk({nm, ".len0_valid"}, A'(out_valid), A'(1));
      chk({nm, ".len0_no_ready"}, A'(in_ready), A'(0));
    end else begin
      beats = 0; g = 0; pat = 0; last = 0;
      while (beats < e.len && g < 200) begin
        drive_beat(e);
        in_valid = 1'b1;
        rdy = in_ready;
        pat = (pat << 1) | int'(rdy);
        tick();
        g++;
        if (rdy) begin beats++; last = cyc; end
      end
      in_valid = 1'b0;
      chk({nm, ".beats_accepted"}, A'(beats), A'(e.len));
      if (e.pchk) chk({nm, ".ready_pattern"}, A'(pat), A'(5'b10101));
      chk({nm, ".ready_low_after_last"}, A'(in_ready), A'(0));
      g = 0;
      while (!out_valid && g < 50) begin tick(); g++; end
      chk({nm, ".latency"}, A'(cyc - last), A'(5));
    end
  endtask

  task automatic collect(string nm);
    exp_t x;
    chk({nm, ".out_valid"}, A'(out_valid), A'(1));
    if (sbq.size() == 0) begin
      chk({nm, ".scoreboard_nonempty"}, A'(0), A'(1));
    end else begin
      x = sbq.pop_front();
      chk({nm, ".result"}, result, x.res);
      chk({nm, ".overflow"}, A'(overflow), A'(x.ovf));
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({nm, ".valid_drop"}, A'(out_valid), A'(0));
    chk({nm, ".busy_fall"}, A'(busy), A'(0));
  endtask

  task automatic small_op(logic [SW-1:0] av, logic [SW-1:0] bv, logic [SA-1:0] eres,
                          logic eovf, string nm);
    int g, last;
    bit rdy;
    s_start = 1'b1; s_len = 16'd1;
    tick();
    s_start = 1'b0;
    chk({nm, ".ovf_cleared_at_start"}, A'(s_overflow), A'(0));
    s_a = {SL{av}}; s_b = {SL{bv}};
    s_in_valid = 1'b1;
    g = 0; rdy = 1'b0; last = 0;
    while (!rdy && g < 20) begin
      rdy = s_in_ready;
      tick();
      g++;
      if (rdy) last = cyc;
    end
    s_in_valid = 1'b0;
    g = 0;
    while (!s_out_valid && g < 50) begin tick(); g++; end
    chk({nm, ".latency"}, A'(cyc - last), A'(5));
    chk({nm, ".result"}, A'(s_result), A'(eres));
    chk({nm, ".overflow"}, A'(s_overflow), A'(eovf));
    tick();
    chk({nm, ".idle"}, A'(s_busy), A'(0));
  endtask

  initial begin
    tbl[0] = '{len: 1, a0: 1,          as: 1,   b0: 1,          bs: 0, res: 80'sd36,    ovf: 1'b0, pchk: 1'b0};
    tbl[1] = '{len: 3, a0: 2,          as: 0,   b0: -3,         bs: 0, res: -80'sd144,  ovf: 1'b0, pchk: 1'b1};
    tbl[2] = '{len: 2, a0: 1,          as: 1,   b0: 1,          bs: 1, res: 80'sd408,   ovf: 1'b0, pchk: 1'b0};
    tbl[3] = '{len: 4, a0: -5,         as: 0,   b0: 7,          bs: 1, res: -80'sd1680, ovf: 1'b0, pchk: 1'b0};
    tbl[4] = '{len: 1, a0: 100,        as: -30, b0: 3,          bs: 0, res: -80'sd120,  ovf: 1'b0, pchk: 1'b0};
    tbl[5] = '{len: 0, a0: 0,          as: 0,   b0: 0,          bs: 0, res: 80'sd0,     ovf: 1'b0, pchk: 1'b0};
    tbl[6] = '{len: 5, a0: 2147483647, as: 0,   b0: 2147483647, bs: 0,
               res: 80'sd184467440565296824360, ovf: 1'b0, pchk: 1'b0};

    reset = 1'b1; start = 1'b0; len_beats = '0; in_valid = 1'b0; out_ready = 1'b1;
    a_vec = '0; b_vec = '0;
    s_start = 1'b0; s_len = '0; s_in_valid = 1'b0; s_out_ready = 1'b1; s_a = '0; s_b = '0;
    tick(); tick();
    reset = 1'b0;
    chk("reset.in_ready", A'(in_ready), A'(0));
    chk("reset.out_valid", A'(out_valid), A'(0));
    chk("reset.result", result, A'(0));
    chk("reset.overflow", A'(overflow), A'(0));
    chk("reset.busy", A'(busy), A'(0));

    for (int i = 0; i < 7; i++) begin
      launch(tbl[i], $sformatf("vec%0d", i), 1'b1);
      collect($sformatf("vec%0d", i));
    end

    // Result held under back-pressure while starts and beats are offered.
    out_ready = 1'b0;
    launch(tbl[0], "stall", 1'b1);
    for (int k = 0; k < 10; k++) begin
      start = k[0]; len_beats = 16'd3; in_valid = 1'b1;
      a_vec = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      tick();
      chk("stall.out_valid", A'(out_valid), A'(1));
      chk("stall.result", result, A'(36));
      chk("stall.overflow", A'(overflow), A'(0));
      chk("stall.in_ready", A'(in_ready), A'(0));
    end
    start = 1'b1; len_beats = 16'd2;
    collect("stall");
    start = 1'b0;
    tick();
    chk("stall.start_in_handshake_ignored", A'(busy), A'(0));

    // Reset mid-operation after 2 of 4 beats.
    begin
      vec_t r;
      int got, g;
      r = tbl[3];
      start = 1'b1; len_beats = 16'd4;
      tick();
      start = 1'b0;
      got = 0; g = 0;
      while (got < 2 && g < 20) begin
        bit rdy;
        drive_beat(r); in_valid = 1'b1; rdy = in_ready;
        tick(); g++;
        if (rdy) got++;
      end
      reset = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("midreset.in_ready", A'(in_ready), A'(0));
      chk("midreset.out_valid", A'(out_valid), A'(0));
      chk("midreset.result", result, A'(0));
      chk("midreset.overflow", A'(overflow), A'(0));
      chk("midreset.busy", A'(busy), A'(0));
      reset = 1'b0;
      tick();
      launch(tbl[0], "post_reset", 1'b1);
      collect("post_reset");
    end

    // Narrow accumulator: 4 * (-128 * -128) = 65536 wraps to 0 with overflow.
    small_op(8'h80, 8'h80, 16'h0000, 1'b1, "narrow_wrap");
    small_op(8'h01, 8'h01, 16'h0004, 1'b0, "narrow_next");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
